// File: rtl/nlp_fir_filter_pkg.sv
// Shared constants and FSM encoding for the NLP low-pass FIR stage and the
// sign-magnitude helpers reused by later NLP stages.
package nlp_fir_filter_pkg;

    localparam int DATA_W = 80;
    localparam int NTAP   = 48;
    localparam int FRAC   = 16;
    localparam int GUARD  = 6;

    localparam logic [DATA_W-1:0] SM_MAX_MAG = {1'b0, {(DATA_W-1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MAC    = 2'd1,
        FINISH = 2'd2
    } fir_state_t;

endpackage

// File: rtl/nlp_fir_filter_sm_mult_q16.sv
// Combinational sign-magnitude Q16 multiply: magnitude truncated toward zero
// after the fraction shift and clamped to the largest representable magnitude.
module sm_mult_q16
    import nlp_fir_filter_pkg::*;
#(
    parameter int N         = DATA_W,
    parameter int FRAC_BITS = FRAC
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] p
);

    localparam int M = N - 1;

    logic [2*M-1:0] full;
    logic [2*M-1:0] scaled;
    logic [M-1:0]   mag;

    always_comb begin
        full   = {{M{1'b0}}, a[M-1:0]} * {{M{1'b0}}, b[M-1:0]};
        scaled = full >> FRAC_BITS;
        mag    = (|scaled[2*M-1:M]) ? '1 : scaled[M-1:0];
        // A zero magnitude always carries a positive sign.
        p      = {(a[M] ^ b[M]) & (|mag), mag};
    end

endmodule

// File: rtl/nlp_fir_filter.sv
// Sequential 48-tap sign-magnitude FIR with its own circular delay line;
// one tap per cycle is accumulated in two's complement under start/done.
module nlp_fir_filter
    import nlp_fir_filter_pkg::*;
#(
    parameter int N = DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] x_in,
    output logic [5:0]   rom_addr,
    input  logic [N-1:0] rom_data,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] y_out
);

    localparam int AW = N + GUARD;
    localparam logic [5:0] LAST = 6'(NTAP - 1);

    fir_state_t state, state_nxt;

    logic [N-1:0]         mem [NTAP];
    logic [5:0]           wr_ptr, j, rd_idx;
    logic [6:0]           idx_sum;
    logic [N-1:0]         prod, result;
    logic [AW-1:0]        prod_ext, acc_mag;
    logic signed [AW-1:0] acc, prod_tc;
    logic [N-2:0]         res_mag;

    // Oldest sample sits just after the write pointer, so coef[47] meets the newest.
    always_comb begin
        idx_sum = {1'b0, wr_ptr} + {1'b0, j} + 7'd1;
        rd_idx  = (idx_sum >= 7'(NTAP)) ? 6'(idx_sum - 7'(NTAP)) : idx_sum[5:0];
    end

    sm_mult_q16 #(
        .N         (N),
        .FRAC_BITS (FRAC)
    ) u_mult (
        .a (mem[rd_idx]),
        .b (rom_data),
        .p (prod)
    );

    always_comb begin
        prod_ext = {{(GUARD+1){1'b0}}, prod[N-2:0]};
        prod_tc  = prod[N-1] ? -$signed(prod_ext) : $signed(prod_ext);
        acc_mag  = acc[AW-1] ? -acc : acc;
        res_mag  = (|acc_mag[AW-1:N-1]) ? '1 : acc_mag[N-2:0];
        result   = {acc[AW-1] & (|res_mag), res_mag};
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = MAC;
            MAC:     if (j == LAST) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        rom_addr = (state == MAC) ? j : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            j      <= '0;
            acc    <= '0;
            y_out  <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mem[wr_ptr] <= x_in;
                        acc         <= '0;
                        j           <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + prod_tc;
                    j   <= (j == LAST) ? '0 : j + 6'd1;
                end
                FINISH: begin
                    y_out  <= result;
                    done   <= 1'b1;
                    wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 6'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nlp_fir_filter.sv
// Bench for nlp_fir_filter: a combinational coefficient ROM plus a
// history-array reference model evaluated with wide integer arithmetic.
module tb_nlp_fir_filter;
    import nlp_fir_filter_pkg::*;

    localparam int W = DATA_W;
    localparam logic [W-1:0] ONE = 80'h10000;

    logic         clk = 1'b0;
    logic         rst, start, busy, done;
    logic [W-1:0] x_in, rom_data, y_out;
    logic [5:0]   rom_addr;

    logic [W-1:0] coef_rom [NTAP];
    logic [W-1:0] alt_rom  [NTAP];
    logic [W-1:0] hist     [NTAP];   // hist[a] holds the sample of age a
    bit           rom_sel = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always_comb rom_data = rom_sel ? alt_rom[rom_addr] : coef_rom[rom_addr];

    nlp_fir_filter #(.N(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .x_in     (x_in),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .busy     (busy),
        .done     (done),
        .y_out    (y_out)
    );

    function automatic logic [W-1:0] sm_of_int(input int v);
        return (v < 0) ? {1'b1, 79'(-v)} : {1'b0, 79'(v)};
    endfunction

    function automatic logic [W-1:0] rand_x();
        logic [95:0] r;
        logic        s;
        r = {$urandom, $urandom, $urandom};
        r = r >> $urandom_range(95, 14);
        s = 1'($urandom_range(1, 0));
        return {s, r[W-2:0]};
    endfunction

    function automatic logic [W-1:0] rom_word(input int idx);
        return rom_sel ? alt_rom[idx] : coef_rom[idx];
    endfunction

    function automatic logic signed [127:0] tap_prod(input logic [W-1:0] x, input logic [W-1:0] h);
        logic [159:0]          p;
        logic signed [127:0]   v;
        p = ({81'b0, x[W-2:0]} * {81'b0, h[W-2:0]}) >> FRAC;
        if (p > 160'(SM_MAX_MAG)) p = 160'(SM_MAX_MAG);
        v = $signed({1'b0, p[126:0]});
        return (x[W-1] ^ h[W-1]) ? -v : v;
    endfunction

    function automatic logic [W-1:0] model_y();
        logic signed [127:0] s;
        logic [127:0]        m;
        s = '0;
        for (int a = 0; a < NTAP; a++) s += tap_prod(hist[a], rom_word(NTAP - 1 - a));
        m = (s < 0) ? -s : s;
        if (m > 128'(SM_MAX_MAG)) m = 128'(SM_MAX_MAG);
        return {(s < 0) ? 1'b1 : 1'b0, m[W-2:0]};
    endfunction

    task automatic model_push(input logic [W-1:0] x);
        for (int a = NTAP - 1; a > 0; a--) hist[a] = hist[a-1];
        hist[0] = x;
    endtask

    task automatic model_clear();
        for (int a = 0; a < NTAP; a++) hist[a] = '0;
    endtask

    // Called at a negedge; returns at the negedge where done is seen (or the budget runs out).
    task automatic drive_sample(input logic [W-1:0] x, output logic [W-1:0] y, output int lat);
        start = 1'b1;
        x_in  = x;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        model_push(x);
        lat = 0;
        while (done !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        y = y_out;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; x_in = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (y_out !== '0) begin n_fail++; $display("FAIL reset_y: got %h expected 0", y_out); end
        n_checks++; if (rom_addr !== 6'd0) begin n_fail++; $display("FAIL reset_rom_addr: got %0d expected 0", rom_addr); end
        rst = 1'b0;
        model_clear();
        @(negedge clk);
    endtask

    task automatic run_impulse(input string tag);
        logic [W-1:0] y, exp, k;
        int lat;
        for (int i = 0; i < NTAP; i++) begin
            drive_sample((i == 0) ? ONE : '0, y, lat);
            exp = model_y();
            n_checks++; if (y !== exp) begin n_fail++; $display("FAIL %s[%0d]: got %h expected %h", tag, i, y, exp); end
            n_checks++; if (lat != 49) begin n_fail++; $display("FAIL %s_latency[%0d]: got %0d expected 49", tag, i, lat); end
            k = 'x;
            case (i)
                0:  k = {1'b1, 79'h46};
                1:  k = {1'b1, 79'h48};
                2:  k = {1'b1, 79'h3C};
                47: k = {1'b1, 79'h46};
                default: ;
            endcase
            if (i <= 2 || i == 47) begin
                n_checks++; if (y !== k) begin n_fail++; $display("FAIL %s_const[%0d]: got %h expected %h", tag, i, y, k); end
            end
        end
    endtask

    task automatic test_impulse();
        run_impulse("impulse");
    endtask

    task automatic test_negative_impulse();
        logic [W-1:0] y, exp;
        int lat;
        drive_sample({1'b1, 79'h20000}, y, lat);
        n_checks++; if (y !== {1'b0, 79'h8C}) begin n_fail++; $display("FAIL neg_impulse_const: got %h expected %h", y, {1'b0, 79'h8C}); end
        for (int i = 0; i < 5; i++) begin
            drive_sample('0, y, lat);
            exp = model_y();
            n_checks++; if (y !== exp) begin n_fail++; $display("FAIL neg_impulse[%0d]: got %h expected %h", i, y, exp); end
        end
    endtask

    task automatic test_latency_handshake();
        logic [W-1:0] xa, xb, exp;
        int k, busy_bad;
        xa = rand_x(); xb = rand_x();
        start = 1'b1; x_in = xa;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        model_push(xa);
        k = 0; busy_bad = 0;
        while (done !== 1'b1 && k < 60) begin
            if (busy !== 1'b1) busy_bad++;
            if (k == 9) begin start = 1'b1; x_in = xb; end
            if (k == 10) start = 1'b0;
            @(negedge clk);
            k++;
        end
        exp = model_y();
        n_checks++; if (k != 49) begin n_fail++; $display("FAIL hs_latency: got %0d expected 49", k); end
        n_checks++; if (busy_bad != 0) begin n_fail++; $display("FAIL hs_busy_high: got %0d low cycles expected 0", busy_bad); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hs_busy_at_done: got %b expected 0", busy); end
        n_checks++; if (y_out !== exp) begin n_fail++; $display("FAIL hs_ignored_start: got %h expected %h", y_out, exp); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL hs_done_width: got %b expected 0", done); end
    endtask

    task automatic test_random();
        logic [W-1:0] x, y, exp;
        int lat;
        for (int i = 0; i < 40; i++) begin
            x = (i == 0) ? {1'b1, 79'h0} : rand_x();
            drive_sample(x, y, lat);
            exp = model_y();
            n_checks++; if (y !== exp) begin n_fail++; $display("FAIL random[%0d]: got %h expected %h", i, y, exp); end
            n_checks++; if (lat != 49) begin n_fail++; $display("FAIL random_latency[%0d]: got %0d expected 49", i, lat); end
        end
    endtask

    task automatic test_wraparound();
        logic [W-1:0] y, exp, prev;
        int lat;
        prev = '0;
        for (int i = 0; i < 100; i++) begin
            drive_sample(ONE, y, lat);
            exp = model_y();
            n_checks++; if (y !== exp) begin n_fail++; $display("FAIL wrap[%0d]: got %h expected %h", i, y, exp); end
            if (i >= 48) begin
                n_checks++; if (y !== prev) begin n_fail++; $display("FAIL wrap_steady[%0d]: got %h expected %h", i, y, prev); end
            end
            prev = exp;
        end
    endtask

    task automatic test_reset_mid_mac();
        int k;
        bit saw_done;
        start = 1'b1; x_in = rand_x();
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (rom_addr !== 6'd20 && k < 60) begin
            @(negedge clk);
            k++;
        end
        n_checks++; if (k != 20) begin n_fail++; $display("FAIL mid_mac_tap20: got %0d cycles expected 20", k); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        saw_done = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL mid_mac_done: got %b expected 0", saw_done); end
        n_checks++; if (y_out !== '0) begin n_fail++; $display("FAIL mid_mac_y: got %h expected 0", y_out); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_mac_busy: got %b expected 0", busy); end
        run_impulse("post_reset_impulse");
    endtask

    task automatic test_saturation();
        logic [W-1:0] x, y, exp;
        int lat;
        for (int i = 0; i < NTAP; i++) begin
            drive_sample(SM_MAX_MAG, y, lat);
            exp = model_y();
            n_checks++; if (y !== exp) begin n_fail++; $display("FAIL sat[%0d]: got %h expected %h", i, y, exp); end
            n_checks++; if (y[W-1] && y[W-2:0] == '0) begin n_fail++; $display("FAIL sat_negzero[%0d]: got %h expected no negative zero", i, y); end
        end
        // Gains of 1.0 and above make individual products clamp.
        for (int t = 0; t < NTAP; t++) begin
            case ($urandom_range(4, 0))
                0: alt_rom[t] = 80'h30000;
                1: alt_rom[t] = 80'h18000;
                2: alt_rom[t] = 80'h10000;
                3: alt_rom[t] = 80'h08000;
                default: alt_rom[t] = '0;
            endcase
            alt_rom[t][W-1] = 1'($urandom_range(1, 0));
        end
        rom_sel = 1'b1;
        for (int i = 0; i < NTAP; i++) begin
            x = ($urandom_range(1, 0) != 0) ? SM_MAX_MAG : rand_x();
            x[W-1] = 1'($urandom_range(1, 0));
            drive_sample(x, y, lat);
            exp = model_y();
            n_checks++; if (y !== exp) begin n_fail++; $display("FAIL clamp[%0d]: got %h expected %h", i, y, exp); end
        end
        rom_sel = 1'b0;
    endtask

    initial begin
        int half [24] = '{-70, -72, -60, -36, 0, 40, 90, 140, 180, 200, 170, 80,
                          -80, -300, -520, -700, -760, -600, -150, 600, 1600, 2700, 3700, 4300};
        for (int t = 0; t < 24; t++) begin
            coef_rom[t]            = sm_of_int(half[t]);
            coef_rom[NTAP - 1 - t] = sm_of_int(half[t]);
        end
        coef_rom[4]  = {1'b1, 79'h0};
        coef_rom[43] = {1'b1, 79'h0};
        for (int t = 0; t < NTAP; t++) alt_rom[t] = '0;
        model_clear();
        rst = 1'b1; start = 1'b0; x_in = '0;
        @(negedge clk);

        test_reset();
        test_impulse();
        test_negative_impulse();
        test_latency_handshake();
        test_random();
        test_wraparound();
        test_reset_mid_mac();
        test_saturation();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
